// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract with borrow: {bo, d} = a - b - bi.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] ext;

    // One extra bit catches the borrow: a - b - bi never goes below -2^DIGIT.
    assign ext = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bi};
    assign d   = ext[DIGIT-1:0];
    assign bo  = ext[DIGIT];

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Digit-serial WIDTH-bit subtractor (x - y - bin) behind valid/ready handshakes,
// processing DIGIT bits per clock through a single registered borrow chain.
module serial_subtractor_nbit
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = clog2(NDIG);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor_nbit: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             x_msb;
    logic             y_msb;
    logic [DIGIT-1:0] d;
    logic             bo;
    logic             accept;

    // NOTE: in_ready is combinational from out_ready so DONE can hand off to a new operation without a bubble.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (x_sh[DIGIT-1:0]),
        .b  (y_sh[DIGIT-1:0]),
        .bi (borrow),
        .d  (d),
        .bo (bo)
    );

    // New digit enters at the top; after NDIG shifts digit 0 sits at the LSB.
    assign res_next = WIDTH'({d, res_sh} >> DIGIT);

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_sh      <= '0;
            y_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            borrow    <= 1'b0;
            x_msb     <= 1'b0;
            y_msb     <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    if (accept) begin
                        x_sh   <= x;
                        y_sh   <= y;
                        borrow <= bin;
                        x_msb  <= x[WIDTH-1];
                        y_msb  <= y[WIDTH-1];
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    x_sh   <= x_sh >> DIGIT;
                    y_sh   <= y_sh >> DIGIT;
                    res_sh <= res_next;
                    borrow <= bo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_DIG) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        diff      <= res_next;
                        bout      <= bo;
                        ovf       <= (x_msb ^ y_msb) & (res_next[WIDTH-1] ^ x_msb);
                        zero      <= ~|res_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Randomised and directed self-checking bench for serial_subtractor_nbit (WIDTH=16, DIGIT=4).
module tb_serial_subtractor_nbit;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] y_i;
    logic             bin_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor_nbit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x_i),
        .y         (y_i),
        .bin       (bin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                         output logic [WIDTH-1:0] e_diff, output logic e_bout,
                         output logic e_ovf, output logic e_zero);
        int r;
        int sr;
        r      = int'(a) - int'(b) - int'(bi);
        sr     = int'($signed(a)) - int'($signed(b)) - int'(bi);
        e_diff = r[WIDTH-1:0];
        e_bout = (r < 0);
        e_ovf  = (sr < -(1 << (WIDTH - 1))) || (sr > (1 << (WIDTH - 1)) - 1);
        e_zero = (e_diff == '0);
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_before_accept", in_ready, 1);
        x_i = a; y_i = b; bin_i = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands: the DUT must have captured them already.
        x_i = WIDTH'($urandom); y_i = WIDTH'($urandom); bin_i = 1'($urandom);
        check("busy_in_ready", in_ready, 0);
        check("busy_out_valid", out_valid, 0);
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_latency"}, lat, NDIG);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic bi);
        logic [WIDTH-1:0] e_diff;
        logic e_bout, e_ovf, e_zero;
        model(a, b, bi, e_diff, e_bout, e_ovf, e_zero);
        check({tag, "_diff"}, diff, e_diff);
        check({tag, "_bout"}, bout, e_bout);
        check({tag, "_ovf"},  ovf,  e_ovf);
        check({tag, "_zero"}, zero, e_zero);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released_out_valid"}, out_valid, 0);
        check({tag, "_released_in_ready"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic bi);
        start_op(a, b, bi);
        wait_done(tag);
        check_result(tag, a, b, bi);
        release_result(tag);
    endtask

    // Directed vectors with independently known answers.
    typedef struct {
        string            tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bi;
        logic [WIDTH-1:0] e_diff;
        logic             e_bout;
        logic             e_ovf;
        logic             e_zero;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic rbi;

        vecs[0] = '{"cross_borrow", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"underflow",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"sovf_bin",     16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"no_sovf",      16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"zero_flag",    16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x_i = '0; y_i = '0; bin_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_flags", {bout, ovf, zero}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bi);
            wait_done(vecs[i].tag);
            check({vecs[i].tag, "_diff"}, diff, vecs[i].e_diff);
            check({vecs[i].tag, "_bout"}, bout, vecs[i].e_bout);
            check({vecs[i].tag, "_ovf"},  ovf,  vecs[i].e_ovf);
            check({vecs[i].tag, "_zero"}, zero, vecs[i].e_zero);
            release_result(vecs[i].tag);
        end

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbi = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) begin ra = 16'h8000; rb = WIDTH'($urandom_range(0, 3)); end
            run_op($sformatf("rand%0d", i), ra, rb, rbi);
        end

        // Backpressure: outputs hold while out_ready stays low.
        start_op(16'h4321, 16'h1234, 1'b1);
        wait_done("bp");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_result("bp_hold", 16'h4321, 16'h1234, 1'b1);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        x_i = 16'h1234; y_i = 16'h0234; bin_i = 1'b0;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        x_i = 16'hDEAD; y_i = 16'hBEEF;
        check("b2b_out_valid_drop", out_valid, 0);
        check("b2b_busy_in_ready", in_ready, 0);
        wait_done("b2b");
        check("b2b_diff", diff, 16'h1000);
        check_result("b2b", 16'h1234, 16'h0234, 1'b0);
        release_result("b2b");

        // Reset during the second BUSY cycle aborts the operation.
        start_op(16'h5555, 16'h1111, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < NDIG + 2; c++) begin
            @(posedge clk); #1;
            check("postrst_no_valid", out_valid, 0);
        end
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done("postrst");
        check("postrst_diff", diff, 16'hFFFE);
        check("postrst_bout", bout, 0);
        release_result("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/serial_subtractor_nbit.md
# serial_subtractor_nbit

Digit-serial N-bit subtractor with borrow-in. It computes DIFF = X − Y − BIN over WIDTH bits, DIGIT bits per clock, using a registered borrow chain. It also reports final borrow, signed overflow and zero. It is the sequential, parametrised successor to the 1-bit and 4-bit subtractors, and sits behind a valid/ready handshake in datapaths where area matters more than latency.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT (elaboration error otherwise).
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- x  in  WIDTH  minuend.
- y  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  X − Y − BIN, modulo 2^WIDTH.
- bout  out  1  final borrow: 1 iff unsigned X < Y + BIN.
- ovf  out  1  signed (two's-complement) overflow.
- zero  out  1  diff == 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, register x, y and bin, clear the digit counter, and go to BUSY. in_valid is ignored whenever in_ready=0.
- BUSY: each cycle, subtract digit k = {b, d} = x[k] − y[k] − borrow.
  - Borrow starts at bin.
  - d is shifted into the top of the result register, filling LSB-first toward the right.
  - b is registered as the next borrow.
  - After digit NDIG−1, go to DONE.
- DONE: out_valid=1.
  - diff holds the full result; bout holds the last digit's borrow.
  - ovf = (x[MSB] ^ y[MSB]) & (diff[MSB] ^ x[MSB]), using the captured x and y.
  - zero = ~|diff.
  - All outputs are held stable until out_ready=1.
- DONE with out_ready=1:
  - If in_valid=1, accept the new operands and go to BUSY (back-to-back).
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This path is combinational from out_ready.
- Operands are captured at acceptance; x, y and bin may change afterwards without effect.
- Arithmetic: unsigned modulo 2^WIDTH. The ovf rule holds for bin ∈ {0,1} (equivalent to x + ~y + ~bin).
- Reset value of every output and state:
  - state=IDLE.
  - out_valid=0, diff=0, bout=0, ovf=0, zero=0.
  - Counter and borrow registers = 0.
  - in_ready=1 after reset.
- Reset asserted mid-BUSY or in DONE aborts the operation. No out_valid is produced for it, and the first operation after reset computes correctly.
- DIGIT=WIDTH degenerates to a single BUSY cycle; behaviour is otherwise identical.

## Timing
- Acceptance at rising edge E: BUSY occupies cycles E+1…E+NDIG, and out_valid is high from edge E+NDIG.
- Latency is NDIG cycles from acceptance to out_valid.
- Throughput with out_ready tied high is one result per NDIG+1 cycles, including the DONE cycle.
- diff, bout, ovf and zero are registered outputs and change only on entry to DONE.
- out_valid falls on the edge after the handshake unless a new result is immediately pending, which cannot occur because NDIG ≥ 1.

## Structure
- Package sub_pkg holds:
  - the state enum type (IDLE, BUSY, DONE);
  - a localparam-style function ndig(WIDTH, DIGIT) returning WIDTH/DIGIT;
  - a counter-width helper clog2(NDIG), with a minimum of 1.
- Sub-module sub_digit: combinational DIGIT-bit subtract with borrow. Inputs are a, b (DIGIT) and bi; outputs are d (DIGIT) and bo. One instance serves all digits.
- The top level contains the FSM, operand shift registers (shifted right by DIGIT each BUSY cycle), the result shift register, the borrow flop and the digit counter.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Cross-digit borrow: x=0x1000, y=0x0001, bin=0 → diff=0x0FFF, bout=0, ovf=0, zero=0; out_valid exactly 4 cycles after acceptance.
- Unsigned underflow: x=0x0000, y=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0.
- Signed overflow with borrow-in: x=0x8000, y=0x0000, bin=1 → diff=0x7FFF, bout=0, ovf=1. Also x=0x7FFF, y=0xFFFF, bin=1 → diff=0x7FFF, ovf=0, bout=1.
- Zero flag: x=0x0005, y=0x0004, bin=1 → diff=0x0000, zero=1, bout=0, ovf=0.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → diff/bout/ovf/zero stable, in_ready=0.
  - Then assert out_ready=1 with in_valid=1 (x=0x1234, y=0x0234) → accepted that cycle; next result is 0x1000 after 4 cycles.
- Reset mid-operation: assert rst during the 2nd BUSY cycle → out_valid=0 and in_ready=1 immediately. Then issue x=0xFFFF, y=0x0001 → diff=0xFFFE, bout=0.
